// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: drives conv1d commands per output position and streams accumulators out
module conv1d_sequencer #(
  parameter int INT32_SIZE = 32,
  parameter int KERNEL_LENGTH = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter logic [6:0] NOP_CMD = 7'h7F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [INT32_SIZE-1:0] cfg_offset,
  input  logic [INT32_SIZE-1:0] cfg_depth,
  input  logic [15:0] cfg_out_len,
  output logic cv_en,
  output logic [6:0] cv_cmd,
  output logic [INT32_SIZE-1:0] cv_inp0,
  output logic [INT32_SIZE-1:0] cv_inp1,
  input  logic [INT32_SIZE-1:0] cv_ret,
  output logic res_valid,
  input  logic res_ready,
  output logic [INT32_SIZE-1:0] res_data,
  output logic [15:0] res_idx,
  output logic refill_req,
  output logic [$clog2(KERNEL_LENGTH)-1:0] refill_slot,
  input  logic refill_ack,
  output logic busy,
  output logic error
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {IDLE, FIN, CFG_OFF, CFG_DEP, SET_X, RUN, POLL, CHK, RD, CAP, OUT, REFILL} state_t;
  state_t state, next;
  logic [INT32_SIZE-1:0] offset, depth;
  logic [15:0] out_len, x, slot_w;
  logic [CW-1:0] cnt;
  logic go, last, timeout;
  assign go = start && !abort && state == IDLE;
  assign slot_w = x % 16'(KERNEL_LENGTH);
  assign last = x == out_len - 16'd1;
  assign timeout = cnt == CW'(TIMEOUT_CYC);
  assign cv_en = 1'b1;
  assign cv_inp0 = '0;
  assign refill_slot = slot_w[$clog2(KERNEL_LENGTH)-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    if (abort) next = IDLE;
    else
      case (state)
        IDLE:    if (start) next = cfg_out_len == 16'd0 ? FIN : CFG_OFF;
        FIN:     next = IDLE;
        CFG_OFF: next = CFG_DEP;
        CFG_DEP: next = SET_X;
        SET_X:   next = RUN;
        RUN:     next = POLL;
        POLL:    next = CHK;
        CHK:     next = cv_ret[0] ? RD : timeout ? IDLE : POLL;
        RD:      next = CAP;
        CAP:     next = OUT;
        OUT:     if (res_ready) next = last ? IDLE : REFILL;
        REFILL:  if (refill_ack) next = SET_X;
        default: next = IDLE;
      endcase
  end
  always_comb begin
    cv_cmd = state == CFG_OFF ? 7'd3 : state == CFG_DEP ? 7'd5 : state == SET_X ? 7'd8 :
             state == RUN ? 7'd6 : state == POLL ? 7'd9 : state == RD ? 7'd7 : NOP_CMD;
    cv_inp1 = state == CFG_OFF ? offset : state == CFG_DEP ? depth :
              state == SET_X ? INT32_SIZE'(slot_w) : '0;
    res_valid = state == OUT && !abort;
    refill_req = state == REFILL && !abort;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset <= '0;
      depth <= '0;
      out_len <= '0;
      x <= '0;
      cnt <= '0;
      error <= 1'b0;
      res_data <= '0;
      res_idx <= '0;
    end else begin
      if (go) begin
        offset <= cfg_offset;
        depth <= cfg_depth;
        out_len <= cfg_out_len;
        x <= '0;
        error <= 1'b0;
      end
      if (state == RUN) cnt <= '0;
      if (state == CHK && !abort && !cv_ret[0]) begin
        if (timeout) error <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
      if (state == CAP) begin
        res_data <= cv_ret;
        res_idx <= x;
      end
      if (state == REFILL && refill_ack && !abort) x <= x + 16'd1;
    end
  end
endmodule
